// File: rtl/chu_gpi_evt_ctrl_if.sv
// MMIO slot bus between the FPro processor side and a GPI event controller.
// The master drives select, strobes, address and write data; the slave returns read data.
interface chu_gpi_evt_ctrl_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/chu_gpi_evt_ctrl.sv
// Debounced switch/button inputs with sticky rise/fall event flags and a maskable
// level interrupt, mapped into one FPro MMIO slot.
module chu_gpi_evt_ctrl #(
  parameter int N_SW     = 4,
  parameter int DB_TICKS = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  chu_gpi_evt_ctrl_if.slave   bus,
  input  logic [N_SW-1:0]     din,
  output logic                irq
);

  localparam int            CW      = $clog2(DB_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_TICKS - 1);

  localparam logic [4:0] A_LEVEL = 5'd0;
  localparam logic [4:0] A_RISE  = 5'd1;
  localparam logic [4:0] A_FALL  = 5'd2;
  localparam logic [4:0] A_REN   = 5'd3;
  localparam logic [4:0] A_FEN   = 5'd4;
  localparam logic [4:0] A_CTRL  = 5'd5;

  logic [N_SW-1:0]         sync1_q, sync2_q;
  logic [N_SW-1:0]         level_q, level_d;
  logic [N_SW-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_SW-1:0]         rise_q, rise_d;
  logic [N_SW-1:0]         fall_q, fall_d;
  logic [N_SW-1:0]         ren_q, ren_d;
  logic [N_SW-1:0]         fen_q, fen_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic                    irq_q, irq_d;

  logic                    wr_en;
  logic [N_SW-1:0]         wr_bits;
  logic [N_SW-1:0]         rise_set, fall_set, rise_clr, fall_clr;

  // Reads are side-effect free, and only the low N_SW write-data bits matter.
  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.wr_data};

  assign wr_en   = bus.cs & bus.write;
  assign wr_bits = bus.wr_data[N_SW-1:0];

  // Per-bit debounce: a mismatch must persist DB_TICKS cycles; bypass follows sync directly.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (ctrl_q[1]) begin
        level_d[i] = sync2_q[i];
      end else if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Flags are set on the edge where level changes; a set beats a same-cycle W1C.
  always_comb begin
    rise_set = level_d & ~level_q & ren_q;
    fall_set = ~level_d & level_q & fen_q;
    rise_clr = (wr_en && bus.addr == A_RISE) ? wr_bits : '0;
    fall_clr = (wr_en && bus.addr == A_FALL) ? wr_bits : '0;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    ren_d    = (wr_en && bus.addr == A_REN)  ? wr_bits : ren_q;
    fen_d    = (wr_en && bus.addr == A_FEN)  ? wr_bits : fen_q;
    ctrl_d   = (wr_en && bus.addr == A_CTRL) ? bus.wr_data[1:0] : ctrl_q;
    irq_d    = ctrl_q[0] & (|(rise_q | fall_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      ctrl_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      ctrl_q  <= ctrl_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      A_LEVEL: bus.rd_data[N_SW-1:0] = level_q;
      A_RISE:  bus.rd_data[N_SW-1:0] = rise_q;
      A_FALL:  bus.rd_data[N_SW-1:0] = fall_q;
      A_REN:   bus.rd_data[N_SW-1:0] = ren_q;
      A_FEN:   bus.rd_data[N_SW-1:0] = fen_q;
      A_CTRL:  bus.rd_data[1:0]      = ctrl_q;
      default: bus.rd_data           = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_gpi_evt_ctrl.sv
// Bench for chu_gpi_evt_ctrl: directed bus transactions queue expected read data and irq,
// and a negedge monitor compares them whenever a read is presented on the bus.
module tb_chu_gpi_evt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       irq;

  chu_gpi_evt_ctrl_if bus ();

  chu_gpi_evt_ctrl #(.N_SW(4), .DB_TICKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .din (din),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every read cycle pops one expectation and checks rd_data and irq.
  always @(negedge clk) begin
    if (bus.cs && bus.read) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read addr=%0d got rd_data=%h", bus.addr, bus.rd_data);
      end else begin
        cur = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== cur.rd) begin
          errors++;
          $display("FAIL %s rd_data got %h expected %h", cur.nm, bus.rd_data, cur.rd);
        end
        checks++;
        if (irq !== cur.irq) begin
          errors++;
          $display("FAIL %s irq got %b expected %b", cur.nm, irq, cur.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input logic ei, input string nm);
    exp_t t;
    t.nm  = nm;
    t.rd  = e;
    t.irq = ei;
    exp_q.push_back(t);
    bus.cs   = 1'b1;
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.cs   = 1'b0;
    bus.read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs      = 1'b1;
    bus.write   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    tick();
    bus.cs      = 1'b0;
    bus.write   = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst         = 1'b1;
    din         = 4'hF;
    bus.cs      = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    idle(3);

    // Reset with inputs high: every address reads 0, writes are held off.
    for (int a = 0; a < 8; a++) rd(5'(a), 32'h0, 1'b0, "reset_read");
    wr(5'd3, 32'hF);
    rd(5'd3, 32'h0, 1'b0, "reset_write_ignored");
    rst = 1'b0;
    idle(5);
    rd(5'd0, 32'h0, 1'b0, "reset_level_clk5");
    rd(5'd0, 32'hF, 1'b0, "reset_level_clk6");
    rd(5'd1, 32'h0, 1'b0, "reset_no_rise");
    rd(5'd2, 32'h0, 1'b0, "reset_no_fall");

    // Debounce: short pulse rejected, held level accepted after exactly 6 clocks.
    din = 4'h0;
    idle(8);
    rd(5'd0, 32'h0, 1'b0, "level_all_low");
    din = 4'h1;
    idle(3);
    din = 4'h0;
    idle(8);
    rd(5'd0, 32'h0, 1'b0, "pulse3_rejected");
    din = 4'h1;
    idle(5);
    rd(5'd0, 32'h0, 1'b0, "hold_clk5");
    rd(5'd0, 32'h1, 1'b0, "hold_clk6");

    // Rising event and interrupt timing, then W1C.
    wr(5'd3, 32'h2);
    wr(5'd5, 32'h1);
    din = 4'h3;
    idle(5);
    rd(5'd1, 32'h0, 1'b0, "rise_before");
    rd(5'd1, 32'h2, 1'b0, "rise_set");
    rd(5'd1, 32'h2, 1'b1, "rise_irq");
    rd(5'd0, 32'h3, 1'b1, "rise_level");
    wr(5'd1, 32'h0);
    rd(5'd1, 32'h2, 1'b1, "w0_no_clear");
    wr(5'd1, 32'h2);
    rd(5'd1, 32'h0, 1'b1, "w1c_cleared");
    rd(5'd1, 32'h0, 1'b0, "w1c_irq_low");

    // W1C on the same edge a new rise is captured: the flag survives.
    din = 4'h1;
    idle(8);
    rd(5'd2, 32'h0, 1'b0, "fall_masked_bit1");
    din = 4'h3;
    idle(5);
    wr(5'd1, 32'h2);
    rd(5'd1, 32'h2, 1'b0, "collision_set_wins");
    rd(5'd1, 32'h2, 1'b1, "collision_irq");
    wr(5'd1, 32'h2);
    idle(1);
    rd(5'd1, 32'h0, 1'b0, "collision_cleared");

    // Falling edge masked, then enabled; disabling enables or irq keeps flags.
    wr(5'd4, 32'h0);
    din = 4'h7;
    idle(8);
    din = 4'h3;
    idle(8);
    rd(5'd2, 32'h0, 1'b0, "fen0_no_fall");
    rd(5'd0, 32'h3, 1'b0, "fen0_level");
    wr(5'd4, 32'h4);
    din = 4'h7;
    idle(8);
    din = 4'h3;
    idle(8);
    rd(5'd2, 32'h4, 1'b1, "fall_set");
    wr(5'd4, 32'h0);
    rd(5'd2, 32'h4, 1'b1, "fen_off_keeps_flag");
    wr(5'd5, 32'h0);
    rd(5'd2, 32'h4, 1'b1, "irq_en_off_lag");
    rd(5'd2, 32'h4, 1'b0, "irq_en_off");
    wr(5'd2, 32'h4);
    rd(5'd2, 32'h0, 1'b0, "fall_cleared");

    // Bypass: a 1-clock pulse on din[3] reaches LEVEL two clocks after it is sampled.
    wr(5'd5, 32'h2);
    din = 4'hB;
    tick();
    din = 4'h3;
    tick();
    rd(5'd0, 32'h3, 1'b0, "bypass_before");
    rd(5'd0, 32'hB, 1'b0, "bypass_pulse");
    rd(5'd0, 32'h3, 1'b0, "bypass_after");
    rd(5'd5, 32'h2, 1'b0, "ctrl_bypass");

    // Register map edges.
    wr(5'd3, 32'hFFFF_FFFF);
    rd(5'd3, 32'hF, 1'b0, "ren_masked_width");
    wr(5'd0, 32'h5);
    rd(5'd0, 32'h3, 1'b0, "level_readonly");
    wr(5'd7, 32'hFFFF_FFFF);
    rd(5'd7, 32'h0, 1'b0, "unmapped_read");
    rd(5'd3, 32'hF, 1'b0, "unmapped_write_ignored");
    rd(5'd5, 32'h2, 1'b0, "ctrl_unchanged");
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, 32'h3, 1'b0, "ctrl_two_bits");
    rd(5'd1, 32'h0, 1'b0, "no_rise_stable");

    // Reset with live configuration clears everything at once.
    rst = 1'b1;
    for (int a = 0; a < 6; a++) rd(5'(a), 32'h0, 1'b0, "reset_again");
    rst = 1'b0;
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
